// File: rtl/kb_key_sequencer.sv
// PS/2 set-2 scan code sequencer: decodes F0/E0 prefixes, tracks Shift/Caps Lock,
// translates make codes to ASCII and queues them in a show-ahead FIFO for a slow consumer.
module kb_key_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [7:0]       scan_code,
  input  logic             scan_ready,
  input  logic             char_ready,
  output logic             char_valid,
  output logic [6:0]       char_out,
  output logic [CNT_W-1:0] fifo_count,
  output logic             shift_held,
  output logic             caps_on,
  output logic             overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  state_t state, state_nxt;
  logic   make_stb, brk_stb;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Extended keys (E0 ...) are swallowed whole, so right-side modifier aliases never touch shift.
  always_comb begin
    state_nxt = state;
    make_stb  = 1'b0;
    brk_stb   = 1'b0;
    if (scan_ready) begin
      case (state)
        IDLE: begin
          if      (scan_code == 8'hF0) state_nxt = BRK;
          else if (scan_code == 8'hE0) state_nxt = EXT;
          else                         make_stb  = 1'b1;
        end
        BRK: begin
          brk_stb   = 1'b1;
          state_nxt = IDLE;
        end
        EXT:     state_nxt = (scan_code == 8'hF0) ? EXT_BRK : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Modifier state
  logic lsh, rsh, caps_held;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lsh       <= 1'b0;
      rsh       <= 1'b0;
      caps_on   <= 1'b0;
      caps_held <= 1'b0;
    end else if (make_stb) begin
      case (scan_code)
        8'h12: lsh <= 1'b1;
        8'h59: rsh <= 1'b1;
        8'h58: begin
          if (!caps_held) caps_on <= ~caps_on;
          caps_held <= 1'b1;
        end
        default: ;
      endcase
    end else if (brk_stb) begin
      case (scan_code)
        8'h12:   lsh       <= 1'b0;
        8'h59:   rsh       <= 1'b0;
        8'h58:   caps_held <= 1'b0;
        default: ;
      endcase
    end
  end

  assign shift_held = lsh | rsh;

  // Translation: letters resolve to lowercase first, then case-fold by shift XOR caps.
  logic [6:0] letter, other, push_char;
  logic       other_hit, map_hit;

  always_comb begin
    letter    = 7'h00;
    other     = 7'h00;
    other_hit = 1'b1;
    case (scan_code)
      8'h1C: letter = 7'h61;  8'h32: letter = 7'h62;  8'h21: letter = 7'h63;
      8'h23: letter = 7'h64;  8'h24: letter = 7'h65;  8'h2B: letter = 7'h66;
      8'h34: letter = 7'h67;  8'h33: letter = 7'h68;  8'h43: letter = 7'h69;
      8'h3B: letter = 7'h6A;  8'h42: letter = 7'h6B;  8'h4B: letter = 7'h6C;
      8'h3A: letter = 7'h6D;  8'h31: letter = 7'h6E;  8'h44: letter = 7'h6F;
      8'h4D: letter = 7'h70;  8'h15: letter = 7'h71;  8'h2D: letter = 7'h72;
      8'h1B: letter = 7'h73;  8'h2C: letter = 7'h74;  8'h3C: letter = 7'h75;
      8'h2A: letter = 7'h76;  8'h1D: letter = 7'h77;  8'h22: letter = 7'h78;
      8'h35: letter = 7'h79;  8'h1A: letter = 7'h7A;
      default: ;
    endcase
    case (scan_code)
      8'h45: other = 7'h30;  8'h16: other = 7'h31;  8'h1E: other = 7'h32;
      8'h26: other = 7'h33;  8'h25: other = 7'h34;  8'h2E: other = 7'h35;
      8'h36: other = 7'h36;  8'h3D: other = 7'h37;  8'h3E: other = 7'h38;
      8'h46: other = 7'h39;  8'h29: other = 7'h20;  8'h5A: other = 7'h0D;
      8'h66: other = 7'h08;
      default: other_hit = 1'b0;
    endcase
    map_hit = other_hit | (letter != 7'h00);
    if (letter != 7'h00)
      push_char = (shift_held ^ caps_on) ? (letter - 7'h20) : letter;
    else
      push_char = other;
  end

  // Character FIFO
  logic [6:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, full, wr_en;

  assign push       = make_stb & map_hit;
  assign char_valid = (fifo_count != '0);
  assign full       = (fifo_count == FULL_CNT);
  assign pop        = char_valid & char_ready;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts the push.
  assign wr_en      = push & (~full | pop);
  assign char_out   = char_valid ? mem[rd_ptr] : 7'h00;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_char;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
      if (push & full & ~pop) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_kb_key_sequencer.sv
// Directed bench for kb_key_sequencer: scan byte sequences with hand-computed ASCII/flags.
module tb_kb_key_sequencer;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic       scan_ready = 1'b0;
  logic       char_ready = 1'b0;
  logic       char_valid;
  logic [6:0] char_out;
  logic [2:0] fifo_count;
  logic       shift_held, caps_on, overflow;

  int pass_cnt = 0;
  int total_cnt = 0;

  kb_key_sequencer #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
    .clk(clk), .resetn(resetn), .scan_code(scan_code), .scan_ready(scan_ready),
    .char_ready(char_ready), .char_valid(char_valid), .char_out(char_out),
    .fifo_count(fifo_count), .shift_held(shift_held), .caps_on(caps_on),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Drives one strobe; returns at the falling edge after the capturing rising edge.
  task automatic send(input logic [7:0] b);
    scan_code  = b;
    scan_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    scan_ready = 1'b0;
  endtask

  task automatic do_reset();
    char_ready = 1'b0;
    scan_ready = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [11:0] got;
    resetn = 1'b0;
    #1;
    got = {char_valid, char_out, fifo_count, shift_held};
    total_cnt++;
    if (got !== 12'h000 || caps_on !== 1'b0 || overflow !== 1'b0)
      $display("FAIL reset_outputs: got %h caps=%b ovf=%b want all 0", got, caps_on, overflow);
    else pass_cnt++;
    do_reset();
  endtask

  task automatic test_basic();
    logic [7:0] b [3]  = '{8'h1C, 8'hF0, 8'h1C};
    logic       ev [3] = '{1'b1, 1'b0, 1'b0};
    do_reset();
    char_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(b[i]);
      total_cnt++;
      if (char_valid !== ev[i] || (ev[i] && char_out !== 7'h61))
        $display("FAIL basic[%0d]: got v=%b c=%h want v=%b c=61", i, char_valid, char_out, ev[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_shift();
    logic [7:0] b  [6] = '{8'h12, 8'h1C, 8'h16, 8'hF0, 8'h12, 8'h1C};
    logic       ev [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [6:0] ec [6] = '{7'h00, 7'h41, 7'h31, 7'h00, 7'h00, 7'h61};
    logic       es [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    char_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send(b[i]);
      total_cnt++;
      if (char_valid !== ev[i] || (ev[i] && char_out !== ec[i]) || shift_held !== es[i])
        $display("FAIL shift[%0d]: got v=%b c=%h sh=%b want v=%b c=%h sh=%b",
                 i, char_valid, char_out, shift_held, ev[i], ec[i], es[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_caps();
    logic [7:0] b  [10] = '{8'h58, 8'h58, 8'h58, 8'hF0, 8'h58, 8'h1C, 8'h12, 8'h1C, 8'h58, 8'h1C};
    logic       ev [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [6:0] ec [10] = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h41, 7'h00, 7'h61, 7'h00, 7'h41};
    logic       ek [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    char_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(b[i]);
      total_cnt++;
      if (char_valid !== ev[i] || (ev[i] && char_out !== ec[i]) || caps_on !== ek[i])
        $display("FAIL caps[%0d]: got v=%b c=%h caps=%b want v=%b c=%h caps=%b",
                 i, char_valid, char_out, caps_on, ev[i], ec[i], ek[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_extended();
    logic [7:0] b [8] = '{8'hE0, 8'h12, 8'hE0, 8'hF0, 8'h12, 8'hE0, 8'h75, 8'h1C};
    do_reset();
    char_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(b[i]);
      total_cnt++;
      if (shift_held !== 1'b0 || char_valid !== (i == 7) || (i == 7 && char_out !== 7'h61))
        $display("FAIL ext[%0d]: got v=%b c=%h sh=%b want v=%b c=61 sh=0",
                 i, char_valid, char_out, shift_held, (i == 7));
      else pass_cnt++;
    end
  endtask

  task automatic test_misc_keys();
    logic [7:0] b  [7] = '{8'h45, 8'h46, 8'h29, 8'h5A, 8'h66, 8'h76, 8'h1A};
    logic       ev [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [6:0] ec [7] = '{7'h30, 7'h39, 7'h20, 7'h0D, 7'h08, 7'h00, 7'h7A};
    do_reset();
    char_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(b[i]);
      total_cnt++;
      if (char_valid !== ev[i] || (ev[i] && char_out !== ec[i]))
        $display("FAIL misc[%0d]: got v=%b c=%h want v=%b c=%h", i, char_valid, char_out, ev[i], ec[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_overflow();
    logic [2:0] en [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(8'h1C);
      total_cnt++;
      if (fifo_count !== en[i] || overflow !== (i == 4))
        $display("FAIL ovf_fill[%0d]: got cnt=%0d ovf=%b want cnt=%0d ovf=%b",
                 i, fifo_count, overflow, en[i], (i == 4));
      else pass_cnt++;
    end
    char_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (char_valid !== 1'b1 || char_out !== 7'h61 || fifo_count !== 3'(4 - i))
        $display("FAIL ovf_drain[%0d]: got v=%b c=%h cnt=%0d want v=1 c=61 cnt=%0d",
                 i, char_valid, char_out, fifo_count, 4 - i);
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if (char_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b1)
      $display("FAIL ovf_empty: got v=%b cnt=%0d ovf=%b want v=0 cnt=0 ovf=1",
               char_valid, fifo_count, overflow);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] b  [4] = '{8'h1C, 8'h32, 8'h21, 8'h23};
    logic [6:0] ec [4] = '{7'h62, 7'h63, 7'h64, 7'h65};
    do_reset();
    for (int i = 0; i < 4; i++) send(b[i]);
    // Full FIFO: simultaneous pop of 'a' and push of 'e' must both succeed.
    char_ready = 1'b1;
    send(8'h24);
    total_cnt++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0 || char_out !== 7'h62)
      $display("FAIL full_pushpop: got cnt=%0d ovf=%b c=%h want cnt=4 ovf=0 c=62",
               fifo_count, overflow, char_out);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total_cnt++;
      if (char_valid !== 1'b1 || char_out !== ec[i])
        $display("FAIL order[%0d]: got v=%b c=%h want v=1 c=%h", i, char_valid, char_out, ec[i]);
      else pass_cnt++;
      @(negedge clk);
    end
    total_cnt++;
    if (char_valid !== 1'b0 || fifo_count !== 3'd0)
      $display("FAIL order_empty: got v=%b cnt=%0d want v=0 cnt=0", char_valid, fifo_count);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    send(8'h12);
    send(8'h1C);
    send(8'h1C);
    send(8'hF0);
    total_cnt++;
    if (fifo_count !== 3'd2 || shift_held !== 1'b1)
      $display("FAIL mid_pre: got cnt=%0d sh=%b want cnt=2 sh=1", fifo_count, shift_held);
    else pass_cnt++;
    #2 resetn = 1'b0;
    #1;
    total_cnt++;
    if (fifo_count !== 3'd0 || char_valid !== 1'b0 || overflow !== 1'b0 || shift_held !== 1'b0)
      $display("FAIL mid_reset: got cnt=%0d v=%b ovf=%b sh=%b want all 0",
               fifo_count, char_valid, overflow, shift_held);
    else pass_cnt++;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    char_ready = 1'b1;
    send(8'h1C);
    total_cnt++;
    if (char_valid !== 1'b1 || char_out !== 7'h61)
      $display("FAIL mid_after: got v=%b c=%h want v=1 c=61", char_valid, char_out);
    else pass_cnt++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_shift();
    test_caps();
    test_extended();
    test_misc_keys();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/kb_key_sequencer.md
Name: kb_key_sequencer

Overview:
- Sits between the PS/2 `keyboard` receiver and downstream text/notepad logic.
- Sequences raw scan codes through a prefix-decoding FSM (F0 break, E0 extended).
- Tracks Shift and Caps Lock state and translates make codes to 7-bit ASCII.
- Buffers the resulting characters in a small FIFO with a valid/ready handshake, so a slow consumer (e.g. a VGA character writer) does not lose keystrokes.

Parameters:
- FIFO_DEPTH, 4, number of character slots; must be a power of 2, minimum 2.
- CNT_W, 3, width of fifo_count; equals log2(FIFO_DEPTH)+1.

Ports:
- clk  input  1  system clock (50 MHz).
- resetn  input  1  asynchronous active-low reset.
- scan_code  input  8  byte from the keyboard receiver.
- scan_ready  input  1  one-cycle strobe; scan_code is valid in that cycle.
- char_ready  input  1  consumer accepts char_out this cycle.
- char_valid  output  1  FIFO non-empty; char_out is valid.
- char_out  output  7  ASCII at the FIFO head.
- fifo_count  output  CNT_W  current occupancy.
- shift_held  output  1  left or right Shift currently down.
- caps_on  output  1  Caps Lock toggle state.
- overflow  output  1  sticky; a character was dropped because the FIFO was full.

Behaviour:
- Reset (resetn=0, asynchronous):
  - All outputs become 0.
  - FSM goes to IDLE.
  - FIFO is emptied.
  - Shift and caps state, and all held flags, are cleared.
  - Applies mid-sequence: a pending F0/E0 prefix is discarded.
- Bytes are consumed only in cycles where scan_ready=1; other cycles leave FSM and modifier state unchanged.
- FSM states: IDLE, BRK, EXT, EXT_BRK.
  - IDLE: F0 -> BRK; E0 -> EXT; any other byte is a make code -> make processing, stay IDLE.
  - BRK: any byte is a break code -> break processing -> IDLE.
  - EXT: F0 -> EXT_BRK; any other byte -> IDLE, ignored (no char, no modifier change).
  - EXT_BRK: any byte -> IDLE, ignored.
  - Consequence: E0 12 and E0 F0 12 never affect shift.
- Make processing:
  - 0x12 sets lsh; 0x59 sets rsh; shift_held = lsh|rsh.
  - 0x58 toggles caps_on only if caps_held=0, then sets caps_held; typematic repeats do not re-toggle.
  - Letters (PS/2 set-2 codes for A..Z):
    - upper = shift_held XOR caps_on.
    - upper=1 -> 0x41..0x5A.
    - upper=0 -> 0x61..0x7A.
  - Digits 0..9 -> 0x30..0x39, shift ignored.
  - 0x29 -> 0x20 (space); 0x5A -> 0x0D (enter); 0x66 -> 0x08 (backspace).
  - Every other code: no push.
  - Typematic repeats of a mappable key push a character on each repeat.
  - Shift and Caps Lock edits take effect from the next byte, not the current one.
- Break processing: 0x12 clears lsh; 0x59 clears rsh; 0x58 clears caps_held; all other codes are ignored. No push.
- FIFO behaviour:
  - A push writes in the scan_ready cycle; char_valid/char_out reflect it on the next clock edge (1-cycle latency when the FIFO was empty).
  - Show-ahead: char_out always equals the head entry while char_valid=1.
  - Pop occurs when char_valid & char_ready. char_out is don't-care when char_valid=0.
  - Push and pop in the same cycle: both succeed, count unchanged. This holds even when full.
  - Push when full with no pop: character dropped, overflow<=1 (held until reset), count stays at FIFO_DEPTH.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH; entries leave in push order.

Test Plan:
- Reset, then scan_ready pulses 1C, then F0, 1C; char_ready=1 -> exactly one char, 0x61 ('a'), char_valid high 1 cycle after the 1C strobe; nothing emitted for F0 1C.
- Sequence 12, 1C, 16, F0 12, 1C -> output 0x41, 0x31, 0x61; shift_held 1 from the cycle after 12 until after F0 12.
- Sequence 58, 58, 58, F0 58, then 1C, then 12 1C -> caps_on=1 after the first 58 only; chars 0x41 then 0x61.
- Sequence E0 12, E0 F0 12, E0 75, then 1C -> shift_held stays 0, no char for the extended keys, then 0x61.
- char_ready=0, five strobes of 1C -> fifo_count=4, overflow=1; then char_ready=1 -> four 0x61 chars, count drains to 0, overflow remains 1.
- Assert resetn=0 between F0 and 1C with 2 chars queued -> count 0, char_valid 0, overflow 0; a subsequent 1C alone is a make code -> 0x61.
